// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the serial boot loader.
// Package name lib_boot is imported by boot_loader and boot_word_asm.
package lib_boot;

   typedef enum logic [2:0] {
      SYNC   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      RUN    = 3'd5
   } BOOT_STATE;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int unsigned MAX_WORDS = 2048;

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian 4-byte word assembler with 2-bit byte index.
// word/word_valid are combinational with the 4th byte strobe.
module boot_word_asm
   import lib_boot::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [23:0] sh_q, sh_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      sh_d  = sh_q;
      idx_d = idx_q;
      if (clr) begin
         sh_d  = '0;
         idx_d = '0;
      end else if (byte_en) begin
         sh_d  = {byte_in, sh_q[23:8]};
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q  <= '0;
         idx_q <= '0;
      end else begin
         sh_q  <= sh_d;
         idx_q <= idx_d;
      end
   end

   assign word       = {byte_in, sh_q};
   assign word_valid = byte_en && !clr && (idx_q == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Framed serial program loader: holds CPU in reset, fills ROM, checks XOR.
// Optional idle timeout inside a frame: define BOOT_LOADER_TIMEOUT_EN.
module boot_loader
   import lib_boot::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        irr,
   input  logic [7:0]  rx_data,
   output logic        ack,
   output logic        rom_w_en,
   output logic [10:0] rom_w_addr,
   output logic [31:0] rom_w_data,
   output logic        cpu_reset,
   output logic        done,
   output logic        err
);

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   BOOT_STATE   state_q, state_d;
   logic        ack_q, ack_d;
   logic        we_q, we_d;
   logic [10:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [10:0] addr_q, addr_d;
   logic [7:0]  csum_q, csum_d;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [11:0] left_q, left_d;

   logic        accept;
   logic [15:0] n_words;
   logic [31:0] word;
   logic        word_valid;

   // One byte per handshake: never accept while ack is high.
   assign accept  = irr && !ack_q && (state_q != RUN);
   assign n_words = {rx_data, len_lo_q};

   boot_word_asm u_asm (
      .clk        (clk),
      .rst_n      (reset_n),
      .clr        (state_q != DATA),
      .byte_en    (accept && (state_q == DATA)),
      .byte_in    (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

`ifdef BOOT_LOADER_TIMEOUT_EN
   logic [31:0] idle_q, idle_d;
   logic        active;
   assign active = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                   (state_q == DATA)   || (state_q == CSUM);
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d  = state_q;
      ack_d    = accept;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      addr_d   = addr_q;
      csum_d   = csum_q;
      len_lo_d = len_lo_q;
      left_d   = left_q;
      unique case (state_q)
         SYNC: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
               state_d = LEN_LO;
               err_d   = 1'b0;
               csum_d  = '0;
               addr_d  = '0;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               if (n_words > MAX_N) begin
                  state_d = SYNC;
                  err_d   = 1'b1;
               end else if (n_words == 16'd0) begin
                  state_d = CSUM;
               end else begin
                  left_d  = n_words[11:0];
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) csum_d = csum_q ^ rx_data;
            if (word_valid) begin
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = word;
               addr_d  = addr_q + 11'd1;
               left_d  = left_q - 12'd1;
               if (left_q == 12'd1) state_d = CSUM;
            end
         end
         CSUM: begin
            if (accept) begin
               if (rx_data == csum_q) begin
                  state_d = RUN;
               end else begin
                  state_d = SYNC;
                  err_d   = 1'b1;
               end
            end
         end
         RUN: ;
         default: state_d = SYNC;
      endcase
`ifdef BOOT_LOADER_TIMEOUT_EN
      idle_d = '0;
      if (active && !accept) begin
         if (idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d = SYNC;
            err_d   = 1'b1;
         end else begin
            idle_d = idle_q + 32'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= SYNC;
         ack_q    <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         csum_q   <= '0;
         len_lo_q <= '0;
         left_q   <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         csum_q   <= csum_d;
         len_lo_q <= len_lo_d;
         left_q   <= left_d;
      end
   end

`ifdef BOOT_LOADER_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) idle_q <= '0;
      else          idle_q <= idle_d;
   end
`endif

   assign ack        = ack_q;
   assign rom_w_en   = we_q;
   assign rom_w_addr = waddr_q;
   assign rom_w_data = wdata_q;
   assign cpu_reset  = (state_q != RUN);
   assign done       = (state_q == RUN);
   assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: frame-level model feeds an expected-write queue.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        irr = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        ack, rom_w_en, cpu_reset, done, err;
   logic [10:0] rom_w_addr;
   logic [31:0] rom_w_data;

   int checks = 0;
   int passes = 0;

   logic [42:0] exp_q[$];
   bit [31:0]   words[$];
   bit [7:0]    frame[$];

   always #5 clk = ~clk;

   boot_loader #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .irr        (irr),
      .rx_data    (rx_data),
      .ack        (ack),
      .rom_w_en   (rom_w_en),
      .rom_w_addr (rom_w_addr),
      .rom_w_data (rom_w_data),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .err        (err)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every write strobe is compared against the scoreboard head.
   always @(posedge clk) begin
      #1;
      if (reset_n && rom_w_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {21'd0, rom_w_addr, rom_w_data}, 64'hDEAD);
         end else begin
            logic [42:0] e;
            e = exp_q.pop_front();
            check("write", {21'd0, rom_w_addr, rom_w_data}, {21'd0, e});
         end
      end
   end

   task automatic send_byte(input bit [7:0] b);
      int n;
      rx_data = b;
      irr = 1'b1;
      n = 0;
      while (1) begin
         @(posedge clk);
         #1;
         if (ack) break;
         n++;
         if (n > 20) begin
            check("ack_timeout", 0, 1);
            break;
         end
      end
      irr = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      irr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Reference: frame from word list, expected writes pushed per spec rules.
   task automatic build_frame(input bit good);
      bit [7:0] x;
      int n;
      n = words.size();
      frame.delete();
      x = 8'h00;
      frame.push_back(8'hA5);
      frame.push_back(8'(n));
      frame.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            frame.push_back(8'(words[i] >> (8 * k)));
            x ^= 8'(words[i] >> (8 * k));
         end
         exp_q.push_back({11'(i), words[i]});
      end
      frame.push_back(good ? x : (x ^ 8'h01));
   endtask

   task automatic send_frame();
      for (int i = 0; i < frame.size(); i++) begin
         if (i == frame.size() - 1) check("cpu_reset_before_csum", cpu_reset, 1);
         send_byte(frame[i]);
      end
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   task automatic drain(input string name);
      repeat (3) @(posedge clk);
      #1;
      check(name, 64'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   initial begin
      int acks;
      int prev;
      int bad_pair;
      #1;
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_ack", ack, 0);
      check("rst_we", rom_w_en, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_addr", rom_w_addr, 0);
      check("rst_data", rom_w_data, 0);
      do_reset();

      // Directed frame from the plan.
      words.delete();
      words.push_back(32'h44332211);
      words.push_back(32'h88776655);
      build_frame(1);
      check("plan_csum_byte", frame[frame.size()-1], 8'h88);
      send_frame();
      check("run_cpu_reset", cpu_reset, 0);
      check("run_done", done, 1);
      check("run_err", err, 0);
      drain("plan_writes_left");

      // Garbage then empty frame.
      do_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      words.delete();
      build_frame(1);
      send_frame();
      check("empty_done", done, 1);
      check("empty_cpu_reset", cpu_reset, 0);
      drain("empty_writes_left");

      // Bad checksum, then good random frame clears err.
      do_reset();
      words.delete();
      words.push_back(32'h44332211);
      words.push_back(32'h88776655);
      build_frame(0);
      send_frame();
      check("bad_err", err, 1);
      check("bad_cpu_reset", cpu_reset, 1);
      check("bad_done", done, 0);
      drain("bad_writes_left");
      rand_words(int'($urandom_range(1, 6)));
      build_frame(1);
      send_byte(frame[0]);
      check("err_cleared_by_sync", err, 0);
      void'(frame.pop_front());
      send_frame();
      check("recover_done", done, 1);
      drain("recover_writes_left");

      // Oversize count.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h08);
      check("over_err", err, 1);
      check("over_cpu_reset", cpu_reset, 1);
      drain("over_writes_left");
      words.delete();
      build_frame(1);
      send_frame();
      check("over_then_run", done, 1);

      // irr held for 5 cycles with one byte.
      do_reset();
      acks = 0;
      prev = 0;
      bad_pair = 0;
      rx_data = 8'h00;
      irr = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (c == 4) irr = 1'b0;
         if (ack) begin
            acks++;
            if (prev != 0) bad_pair = 1;
         end
         prev = int'(ack);
      end
      check("held_irr_acks", acks, 3);
      check("held_irr_no_back2back", bad_pair, 0);

      // Randomized frames, good and bad.
      for (int it = 0; it < 4; it++) begin
         bit g;
         do_reset();
         g = 1'($urandom);
         rand_words(int'($urandom_range(1, 8)));
         build_frame(g);
         send_frame();
         check("rand_done", done, 64'(g));
         check("rand_err", err, 64'(!g));
         drain("rand_writes_left");
      end

      // Reset mid-word.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      reset_n = 1'b0;
      #1;
      check("mid_cpu_reset", cpu_reset, 1);
      check("mid_ack", ack, 0);
      check("mid_we", rom_w_en, 0);
      check("mid_done", done, 0);
      check("mid_err", err, 0);
      check("mid_addr", rom_w_addr, 0);
      check("mid_data", rom_w_data, 0);
      do_reset();
      send_byte(8'h44);
      drain("mid_writes_left");

`ifdef BOOT_LOADER_TIMEOUT_EN
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      repeat (15) @(posedge clk);
      #1;
      check("to_err_early", err, 0);
      @(posedge clk);
      #1;
      check("to_err", err, 1);
      check("to_cpu_reset", cpu_reset, 1);
      drain("to_writes_left");
`endif

      // Full 2048-word frame with address wrap.
      do_reset();
      rand_words(2048);
      build_frame(1);
      send_frame();
      check("max_done", done, 1);
      check("max_last_addr", rom_w_addr, 11'd2047);
      drain("max_writes_left");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
